asic_scanctrl: RTL

- Scan-chain controller: the driving end of the scan interface formed by chained scan flops (d/si/se/q).
- Loads a parallel pattern into one scan chain serially and pulses capture (se low).
- Unloads the captured chain state serially and compares it against an expected vector under a mask.
- Sits between a test-access/register block and one chain of scan flops.

---
 rtl/asic_scanctrl_pkg.sv | 10 +
 rtl/asic_scanctrl_sreg.sv | 17 +
 rtl/asic_scanctrl.sv | 74 +++++++
 3 files changed

// File: rtl/asic_scanctrl_pkg.sv
// asic_scanctrl_pkg: shared state encoding and width helper for the scan-chain controller
package asic_scanctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/asic_scanctrl_sreg.sv
// asic_scanctrl_sreg: parallel-load, serial-in shift register shifting toward the MSB
module asic_scanctrl_sreg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  input  logic         si,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= {q[W-2:0], si};
endmodule

// File: rtl/asic_scanctrl.sv
// asic_scanctrl: loads a pattern into one scan chain, pulses capture, unloads and compares under mask
module asic_scanctrl
  import asic_scanctrl_pkg::*;
#(
  parameter int    N      = 32,
  parameter int    CAPCYC = 1,
  parameter logic  FILL   = 1'b0,
  parameter string PROP   = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         start,
  input  logic [N-1:0] pattern,
  input  logic [N-1:0] expected,
  input  logic [N-1:0] mask,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         fail,
  output logic         scan_en,
  output logic         scan_in,
  input  logic         scan_out
);
  localparam int CW = clog2((N > CAPCYC ? N : CAPCYC) + 1);
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0] exp_q, msk_q, ld_q, unl_nxt;
  logic accept, shift_last, cap_last;
  assign accept = st == IDLE && start;
  assign shift_last = cnt == CW'(N - 1);
  assign cap_last = cnt == CW'(CAPCYC - 1);
  assign busy = st != IDLE;
  assign done = st == DONE;
  assign unl_nxt = {result[N-2:0], scan_out};
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = shift_last ? CAPTURE : LOAD;
      CAPTURE: nxt = cap_last ? UNLOAD : CAPTURE;
      UNLOAD:  nxt = shift_last ? DONE : UNLOAD;
      default: nxt = IDLE;
    endcase
  end
  // scan_in is registered, so the first pattern bit comes straight from the port on the accepting edge
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      st      <= IDLE;
      cnt     <= '0;
      scan_en <= 1'b0;
      scan_in <= 1'b0;
      exp_q   <= '0;
      msk_q   <= '0;
      fail    <= 1'b0;
    end else begin
      st      <= nxt;
      cnt     <= nxt != st ? '0 : cnt + 1'b1;
      scan_en <= nxt == LOAD || nxt == UNLOAD;
      scan_in <= accept ? pattern[N-1] : nxt == LOAD ? ld_q[N-1] : FILL;
      if (accept) begin
        exp_q <= expected;
        msk_q <= mask;
      end
      fail <= accept ? 1'b0 : (st == UNLOAD && nxt == DONE) ? |((unl_nxt ^ exp_q) & msk_q) : fail;
    end
  asic_scanctrl_sreg #(.W(N)) u_load (
    .clk(clk), .nreset(nreset), .load(accept), .shift(st == LOAD),
    .din({pattern[N-2:0], 1'b0}), .si(1'b0), .q(ld_q)
  );
  asic_scanctrl_sreg #(.W(N)) u_unload (
    .clk(clk), .nreset(nreset), .load(accept), .shift(st == UNLOAD),
    .din({N{1'b0}}), .si(scan_out), .q(result)
  );
endmodule
